// File: rtl/datapath_pkg.sv
// ---------------------------------------------------------------------------
// datapath_pkg
// Shared datapath types for the matrix load/store path.
//   MATRIX_DIM    : rows per matrix and elements per row
//   MATRIX_ELEM_W : element width in bits
//   matrix_row_t  : one full matrix row (MATRIX_DIM * MATRIX_ELEM_W bits)
//   mls_state_t   : state encoding of the matrix load/store responder
// ---------------------------------------------------------------------------
package datapath_pkg;

   localparam int MATRIX_DIM    = 4;
   localparam int MATRIX_ELEM_W = 16;

   typedef logic [MATRIX_DIM*MATRIX_ELEM_W-1:0] matrix_row_t;

   typedef enum logic [2:0] {
      IDLE,
      LD_REQ,
      ST_RD,
      ST_REQ,
      DONE
   } mls_state_t;

endpackage

// File: rtl/mls_addr_gen.sv
// ---------------------------------------------------------------------------
// mls_addr_gen
// Row address generator for the matrix load/store responder. Holds the
// current row address and the row counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a transfer at base, remember stride, row = 0
//   base       : byte address of row 0
//   stride     : byte stride between consecutive rows
//   step       : advance to the next row (addr += stride, row++)
//   addr       : current row address
//   row        : current row index
//   last       : current row is the final row of the matrix
// ---------------------------------------------------------------------------
module mls_addr_gen #(
   parameter  int DIM    = 4,
   parameter  int ADDR_W = 32,
   localparam int ROW_W  = $clog2(DIM)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] stride,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic [ROW_W-1:0]  row,
   output logic              last
);

   logic [ADDR_W-1:0] stride_q;

   // The address is accumulated rather than computed as base + row*stride,
   // which gives the same result modulo 2^ADDR_W without a multiplier.
   // Wrap-around past the top of the address space is intentionally silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= '0;
         row      <= '0;
         stride_q <= '0;
      end else if (load) begin
         addr     <= base;
         row      <= '0;
         stride_q <= stride;
      end else if (step) begin
         addr     <= addr + stride_q;
         row      <= row + 1'b1;
      end
   end

   // The owner only steps while last is low, so the counter never wraps
   // within a transfer.
   always_comb begin
      last = (row == ROW_W'(DIM-1));
   end

endmodule

// File: rtl/matrix_ls_resp.sv
// ---------------------------------------------------------------------------
// matrix_ls_resp
// Responder end of the matrix load/store request interface. Moves a matrix
// row by row between memory and the matrix register file and returns a
// one-cycle mhit pulse on completion.
//   CLK, nRST   : clock, asynchronous active-low reset
//   ls_in       : request, [0]=load, [1]=store (load wins if both set)
//   rd_in       : matrix register (load destination / store source)
//   stride_in   : byte stride between rows
//   addr_in     : base byte address of row 0
//   busy        : high whenever a transfer is in progress
//   mhit        : one-cycle completion pulse
//   mem_*       : memory request port (ready same cycle, read data same cycle)
//   mrf_w*      : matrix register file row write port
//   mrf_r*      : matrix register file row read port (data one cycle later)
// ---------------------------------------------------------------------------
module matrix_ls_resp
   import datapath_pkg::*;
#(
   parameter  int DIM    = MATRIX_DIM,
   parameter  int ELEM_W = MATRIX_ELEM_W,
   parameter  int ADDR_W = 32,
   parameter  int MREG_W = 4,
   localparam int ROW_W  = $clog2(DIM),
   localparam int DATA_W = DIM*ELEM_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [1:0]        ls_in,
   input  logic [MREG_W-1:0] rd_in,
   input  logic [ADDR_W-1:0] stride_in,
   input  logic [ADDR_W-1:0] addr_in,
   output logic              busy,
   output logic              mhit,
   output logic              mem_req,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mrf_wen,
   output logic [MREG_W-1:0] mrf_waddr,
   output logic [ROW_W-1:0]  mrf_wrow,
   output logic [DATA_W-1:0] mrf_wdata,
   output logic              mrf_ren,
   output logic [MREG_W-1:0] mrf_raddr,
   output logic [ROW_W-1:0]  mrf_rrow,
   input  logic [DATA_W-1:0] mrf_rdata
);

   mls_state_t        state;
   logic [MREG_W-1:0] reg_q;
   logic [DATA_W-1:0] row_buf;
   logic              buf_valid;

   logic              ag_load;
   logic              ag_step;
   logic [ADDR_W-1:0] cur_addr;
   logic [ROW_W-1:0]  cur_row;
   logic              last_row;

   // The address generator is loaded on request acceptance and stepped on
   // every accepted memory beat except the final one.
   always_comb begin
      ag_load = (state == IDLE) && (ls_in != 2'b00);
      ag_step = ((state == LD_REQ) || (state == ST_REQ)) && mem_ready && !last_row;
   end

   mls_addr_gen #(
      .DIM    (DIM),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk    (CLK),
      .rst_n  (nRST),
      .load   (ag_load),
      .base   (addr_in),
      .stride (stride_in),
      .step   (ag_step),
      .addr   (cur_addr),
      .row    (cur_row),
      .last   (last_row)
   );

   // Main control FSM. The register file returns read data in the first
   // cycle of ST_REQ, so that cycle forwards mrf_rdata straight to memory
   // and also captures it into row_buf; if memory stalls, the following
   // cycles replay the captured copy so mem_wdata stays stable.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         reg_q     <= '0;
         row_buf   <= '0;
         buf_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ls_in[0]) begin
                  state <= LD_REQ;
                  reg_q <= rd_in;
               end else if (ls_in[1]) begin
                  state <= ST_RD;
                  reg_q <= rd_in;
               end
            end
            LD_REQ: begin
               if (mem_ready && last_row) begin
                  state <= DONE;
               end
            end
            ST_RD: begin
               state     <= ST_REQ;
               buf_valid <= 1'b0;
            end
            ST_REQ: begin
               if (!buf_valid) begin
                  row_buf   <= mrf_rdata;
                  buf_valid <= 1'b1;
               end
               if (mem_ready) begin
                  buf_valid <= 1'b0;
                  state     <= last_row ? DONE : ST_RD;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output decode from the registered state. Every output is zero outside
   // the state that owns it, so an idle or reset responder presents an
   // all-zero interface. The register file write is qualified by mem_ready
   // because read data is only valid in the accepting cycle.
   always_comb begin
      busy      = (state != IDLE);
      mhit      = (state == DONE);
      mem_req   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mrf_wen   = 1'b0;
      mrf_waddr = '0;
      mrf_wrow  = '0;
      mrf_wdata = '0;
      mrf_ren   = 1'b0;
      mrf_raddr = '0;
      mrf_rrow  = '0;
      case (state)
         LD_REQ: begin
            mem_req  = 1'b1;
            mem_addr = cur_addr;
            if (mem_ready) begin
               mrf_wen   = 1'b1;
               mrf_waddr = reg_q;
               mrf_wrow  = cur_row;
               mrf_wdata = mem_rdata;
            end
         end
         ST_RD: begin
            mrf_ren   = 1'b1;
            mrf_raddr = reg_q;
            mrf_rrow  = cur_row;
         end
         ST_REQ: begin
            mem_req   = 1'b1;
            mem_wen   = 1'b1;
            mem_addr  = cur_addr;
            mem_wdata = buf_valid ? row_buf : mrf_rdata;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_matrix_ls_resp.sv
// ---------------------------------------------------------------------------
// tb_matrix_ls_resp
// Self-checking bench for matrix_ls_resp. A behavioural memory and matrix
// register file sit around the responder; expected memory beats and
// register file writes are queued when a request is issued and consumed
// as the responder produces them.
// ---------------------------------------------------------------------------
module tb_matrix_ls_resp;

   logic        clk;
   logic        nrst;
   logic [1:0]  ls_in;
   logic [3:0]  rd_in;
   logic [31:0] stride_in;
   logic [31:0] addr_in;
   logic        busy;
   logic        mhit;
   logic        mem_req;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_ready;
   logic [63:0] mem_rdata;
   logic        mrf_wen;
   logic [3:0]  mrf_waddr;
   logic [1:0]  mrf_wrow;
   logic [63:0] mrf_wdata;
   logic        mrf_ren;
   logic [3:0]  mrf_raddr;
   logic [1:0]  mrf_rrow;
   logic [63:0] mrf_rdata;

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [63:0] data;
   } mem_exp_t;

   typedef struct {
      logic [3:0]  rg;
      logic [1:0]  row;
      logic [63:0] data;
   } mrf_exp_t;

   mem_exp_t mem_q[$];
   mrf_exp_t mrf_q[$];

   int vectors     = 0;
   int miscompares = 0;
   int cycle_cnt   = 0;
   int mhit_count  = 0;
   int mhit_cycle  = 0;
   int acc_cycle   = 0;
   int prev_mhits  = 0;

   logic        stall_prev = 1'b0;
   logic [31:0] stall_addr = '0;
   mem_exp_t    mon_me;
   mrf_exp_t    mon_fe;

   matrix_ls_resp dut (
      .CLK       (clk),
      .nRST      (nrst),
      .ls_in     (ls_in),
      .rd_in     (rd_in),
      .stride_in (stride_in),
      .addr_in   (addr_in),
      .busy      (busy),
      .mhit      (mhit),
      .mem_req   (mem_req),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .mrf_wen   (mrf_wen),
      .mrf_waddr (mrf_waddr),
      .mrf_wrow  (mrf_wrow),
      .mrf_wdata (mrf_wdata),
      .mrf_ren   (mrf_ren),
      .mrf_raddr (mrf_raddr),
      .mrf_rrow  (mrf_rrow),
      .mrf_rdata (mrf_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // Memory read data is a fixed function of the address.
   function automatic logic [63:0] memData(input logic [31:0] a);
      return {a[15:0] ^ 16'h1234, a[31:16], ~a[15:0], 16'hC0DE};
   endfunction

   // Register file contents are a fixed function of register and row.
   function automatic logic [63:0] rfData(input logic [3:0] rg, input logic [1:0] row);
      return {4'hA, 8'h00, rg, 14'h0, row, 16'h5A5A ^ {12'h0, rg}, 8'hC3, 6'h0, row};
   endfunction

   assign mem_rdata = memData(mem_addr);

   // Synchronous-read register file: data valid only in the cycle after mrf_ren.
   always @(posedge clk or negedge nrst) begin
      if (!nrst)
         mrf_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
      else if (mrf_ren)
         mrf_rdata <= rfData(mrf_raddr, mrf_rrow);
      else
         mrf_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic reportFail(input string tag);
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s: event occurred with nothing expected", tag);
   endtask

   // Monitor: consumes expected beats/writes and checks stall behaviour.
   always @(negedge clk) begin
      if (!nrst) begin
         stall_prev = 1'b0;
      end else begin
         if (mem_req && mem_ready) begin
            if (mem_q.size() == 0) begin
               reportFail("mem_unexpected");
            end else begin
               mon_me = mem_q.pop_front();
               checkOutput("mem_addr", 64'(mem_addr), 64'(mon_me.addr));
               checkOutput("mem_wen", 64'(mem_wen), 64'(mon_me.wen));
               if (mon_me.wen)
                  checkOutput("mem_wdata", mem_wdata, mon_me.data);
            end
         end
         if (mrf_wen) begin
            checkOutput("mrf_wen_with_ready", 64'(mem_ready), 64'd1);
            if (mrf_q.size() == 0) begin
               reportFail("mrf_unexpected");
            end else begin
               mon_fe = mrf_q.pop_front();
               checkOutput("mrf_waddr", 64'(mrf_waddr), 64'(mon_fe.rg));
               checkOutput("mrf_wrow", 64'(mrf_wrow), 64'(mon_fe.row));
               checkOutput("mrf_wdata", mrf_wdata, mon_fe.data);
            end
         end
         if (stall_prev) begin
            checkOutput("stall_hold_req", 64'(mem_req), 64'd1);
            checkOutput("stall_hold_addr", 64'(mem_addr), 64'(stall_addr));
         end
         stall_prev = mem_req && !mem_ready;
         stall_addr = mem_addr;
         if (mhit) begin
            mhit_count++;
            mhit_cycle = cycle_cnt;
         end
      end
   end

   // Issue one request; called just after a rising edge while idle.
   // Returns one cycle later with ls_in cleared.
   task automatic applyStimulus(input logic [1:0] ls, input logic [3:0] rg,
                                input logic [31:0] stride, input logic [31:0] base);
      mem_exp_t    me;
      mrf_exp_t    fe;
      logic [31:0] a;
      for (int r = 0; r < 4; r++) begin
         a = base + 32'(r) * stride;
         me.addr = a;
         if (ls[0]) begin
            me.wen  = 1'b0;
            me.data = '0;
            fe.rg   = rg;
            fe.row  = 2'(r);
            fe.data = memData(a);
            mrf_q.push_back(fe);
         end else begin
            me.wen  = 1'b1;
            me.data = rfData(rg, 2'(r));
         end
         mem_q.push_back(me);
      end
      ls_in      = ls;
      rd_in      = rg;
      stride_in  = stride;
      addr_in    = base;
      acc_cycle  = cycle_cnt;
      prev_mhits = mhit_count;
      @(posedge clk);
      #1;
      ls_in = 2'b00;
      checkOutput("busy_after_accept", 64'(busy), 64'd1);
   endtask

   // Wait (bounded) for the completion pulse, check latency, then confirm
   // no further pulse and that every queued expectation was consumed.
   task automatic waitMhit(input string tag, input int exp_lat);
      int guard = 0;
      while (mhit_count == prev_mhits && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (mhit_count == prev_mhits) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL %s_timeout: observed no mhit expected mhit", tag);
      end else begin
         checkOutput({tag, "_latency"}, 64'(mhit_cycle - acc_cycle), 64'(exp_lat));
      end
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      checkOutput({tag, "_single_mhit"}, 64'(mhit_count), 64'(prev_mhits + 1));
      checkOutput({tag, "_mem_drained"}, 64'(mem_q.size()), 64'd0);
      checkOutput({tag, "_mrf_drained"}, 64'(mrf_q.size()), 64'd0);
      checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic checkIdleOutputs(input string pfx);
      checkOutput({pfx, "_busy"}, 64'(busy), 64'd0);
      checkOutput({pfx, "_mhit"}, 64'(mhit), 64'd0);
      checkOutput({pfx, "_strobes"}, 64'({mem_req, mem_wen, mrf_wen, mrf_ren}), 64'd0);
      checkOutput({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
      checkOutput({pfx, "_mem_wdata"}, mem_wdata, 64'd0);
      checkOutput({pfx, "_mrf_wdata"}, mrf_wdata, 64'd0);
      checkOutput({pfx, "_mrf_idx"}, 64'({mrf_waddr, mrf_wrow, mrf_raddr, mrf_rrow}), 64'd0);
   endtask

   initial begin
      nrst      = 1'b0;
      ls_in     = 2'b00;
      rd_in     = '0;
      stride_in = '0;
      addr_in   = '0;
      mem_ready = 1'b1;
      #3;
      checkIdleOutputs("reset");
      @(posedge clk);
      #1;
      nrst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic load");
      applyStimulus(2'b01, 4'd3, 32'h20, 32'h100);
      waitMhit("load", 5);

      $display("[TB] basic store");
      applyStimulus(2'b10, 4'd5, 32'h8, 32'h200);
      waitMhit("store", 9);

      $display("[TB] load with 3-cycle stall on row 1");
      applyStimulus(2'b01, 4'd7, 32'h40, 32'h1000);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      mem_ready = 1'b1;
      waitMhit("stall_load", 8);

      $display("[TB] ls_in=11 treated as load, toggles ignored while busy");
      applyStimulus(2'b11, 4'd9, 32'h4, 32'h300);
      ls_in = 2'b10;
      @(posedge clk);
      #1;
      ls_in = 2'b01;
      @(posedge clk);
      #1;
      ls_in = 2'b11;
      @(posedge clk);
      #1;
      ls_in = 2'b00;
      waitMhit("both_bits", 5);

      $display("[TB] address wrap-around");
      applyStimulus(2'b01, 4'd1, 32'h10, 32'hFFFF_FFF0);
      waitMhit("wrap", 5);

      $display("[TB] stride zero store");
      applyStimulus(2'b10, 4'd12, 32'h0, 32'h440);
      waitMhit("stride0", 9);

      $display("[TB] reset during row 2 of a store");
      applyStimulus(2'b10, 4'd6, 32'h10, 32'h800);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      nrst = 1'b0;
      #1;
      checkIdleOutputs("midop_reset");
      mem_q.delete();
      mrf_q.delete();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      nrst = 1'b1;
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      checkOutput("midop_reset_no_mhit", 64'(mhit_count), 64'(prev_mhits));

      $display("[TB] load after reset");
      applyStimulus(2'b01, 4'd2, 32'h20, 32'h100);
      waitMhit("post_reset_load", 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
